mem_access_unit: RTL and testbench

//  CPU-side initiator for the cache request interface (ADDR/DIN/WE/RREQ -> DOUT/RDY).

---
 rtl/mem_access_pkg.sv | 31 +++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 tb/tb_mem_access_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and helpers for the load/store cache initiator.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_GAP,
    ST_WR_WAIT,
    ST_ERR_OUT
  } state_t;

  // Bits needed to count up to 'cycles' (at least 1).
  function automatic int tmo_width(input int cycles);
    int w;
    w = 1;
    while ((1 << w) <= cycles) w++;
    return w;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lane[0]) ||
           ((size == SZ_WORD) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction / extension for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load   = i_word;
    o_merged = i_word;
    case (i_size)
      SZ_BYTE: begin
        o_load = i_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        o_load = i_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
        if (i_lane[1]) o_merged[31:16] = i_wdata;
        else           o_merged[15:0]  = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for the cache request interface; sub-word stores use
// read / gap / write so the cache sees a fresh request edge for the write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        OP_VALID,
  output logic        OP_READY,
  input  logic        OP_WE,
  input  logic [1:0]  OP_SIZE,
  input  logic        OP_UNSIGNED,
  input  logic [31:0] OP_ADDR,
  input  logic [31:0] OP_WDATA,
  output logic        RES_VALID,
  output logic [31:0] RES_DATA,
  output logic        RES_ERR,
  output logic [31:0] ADDR,
  output logic [31:0] DIN,
  output logic        WE,
  output logic        RREQ,
  input  logic [31:0] DOUT,
  input  logic        RDY
);

  localparam int CW = tmo_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  state_t          r_state, w_state_nxt;
  logic            r_op_we;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [1:0]      r_lane;
  logic [15:0]     r_wdata;
  logic [CW-1:0]   r_cnt;
  logic            r_first;

  logic            w_accept, w_bad, w_rdy, w_tmo, w_waiting, w_issue;
  logic [31:0]     w_load, w_merged;
  logic            w_rreq_nxt, w_we_nxt, w_err_nxt, w_vld_nxt;
  logic [31:0]     w_addr_nxt, w_din_nxt, w_data_nxt;

  assign OP_READY  = (r_state == ST_IDLE);
  assign w_accept  = OP_VALID & OP_READY;
  assign w_bad     = misaligned(OP_SIZE, OP_ADDR[1:0]);
  assign w_waiting = (r_state == ST_RD_WAIT) || (r_state == ST_WR_WAIT);
  // RDY in the first request cycle belongs to a previous access, never ours.
  assign w_rdy     = RDY & ~r_first;
  assign w_tmo     = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);
  assign w_issue   = ((w_state_nxt == ST_RD_WAIT) && (r_state != ST_RD_WAIT)) ||
                     ((w_state_nxt == ST_WR_WAIT) && (r_state != ST_WR_WAIT));

  mem_lane_align u_align (
    .i_word     (DOUT),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (w_bad)                           w_state_nxt = ST_ERR_OUT;
        else if (OP_WE && OP_SIZE == SZ_WORD) w_state_nxt = ST_WR_WAIT;
        else                                 w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (w_rdy)      w_state_nxt = r_op_we ? ST_GAP : ST_IDLE;
        else if (w_tmo) w_state_nxt = ST_ERR_OUT;
      end
      ST_GAP:     w_state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (w_rdy)      w_state_nxt = ST_IDLE;
        else if (w_tmo) w_state_nxt = ST_ERR_OUT;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition being taken.
  always_comb begin
    w_rreq_nxt = (w_state_nxt == ST_RD_WAIT);
    w_we_nxt   = (w_state_nxt == ST_WR_WAIT);
    w_err_nxt  = (w_state_nxt == ST_ERR_OUT);
    w_vld_nxt  = w_err_nxt;
    w_data_nxt = '0;
    w_addr_nxt = ADDR;
    w_din_nxt  = DIN;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_addr_nxt = {OP_ADDR[31:2], 2'b00};
        if (OP_WE && OP_SIZE == SZ_WORD) w_din_nxt = OP_WDATA;
      end
      ST_RD_WAIT: if (w_rdy) begin
        if (r_op_we) begin
          w_din_nxt = w_merged;
        end else begin
          w_vld_nxt  = 1'b1;
          w_data_nxt = w_load;
        end
      end
      ST_WR_WAIT: if (w_rdy) w_vld_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RES_VALID <= 1'b0;
      RES_ERR   <= 1'b0;
      RES_DATA  <= '0;
      ADDR      <= '0;
      DIN       <= '0;
      WE        <= 1'b0;
      RREQ      <= 1'b0;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_op_we   <= 1'b0;
      r_size    <= SZ_BYTE;
      r_uns     <= 1'b0;
      r_lane    <= 2'b00;
      r_wdata   <= '0;
    end else begin
      RES_VALID <= w_vld_nxt;
      RES_ERR   <= w_err_nxt;
      RES_DATA  <= w_data_nxt;
      ADDR      <= w_addr_nxt;
      DIN       <= w_din_nxt;
      WE        <= w_we_nxt;
      RREQ      <= w_rreq_nxt;
      if (w_issue) begin
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (w_waiting) begin
        r_cnt   <= r_cnt + CW'(1);
        r_first <= 1'b0;
      end
      if (w_accept) begin
        r_op_we <= OP_WE;
        r_size  <= OP_SIZE;
        r_uns   <= OP_UNSIGNED;
        r_lane  <= OP_ADDR[1:0];
        r_wdata <= OP_WDATA[15:0];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + random load/store bench with an inline cache responder and an arithmetic result model.
module tb_mem_access_unit;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        OP_VALID = 1'b0, OP_WE = 1'b0, OP_UNSIGNED = 1'b0;
  logic [1:0]  OP_SIZE = 2'b00;
  logic [31:0] OP_ADDR = '0, OP_WDATA = '0, DOUT = '0;
  logic        RDY = 1'b0;
  logic        OP_READY, RES_VALID, RES_ERR, WE, RREQ;
  logic [31:0] RES_DATA, ADDR, DIN;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem [0:63];

  mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .OP_VALID(OP_VALID), .OP_READY(OP_READY), .OP_WE(OP_WE), .OP_SIZE(OP_SIZE),
    .OP_UNSIGNED(OP_UNSIGNED), .OP_ADDR(OP_ADDR), .OP_WDATA(OP_WDATA),
    .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
    .ADDR(ADDR), .DIN(DIN), .WE(WE), .RREQ(RREQ), .DOUT(DOUT), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: treat the access as nb bytes at byte offset, masked and shifted.
  function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd, input logic [31:0] old,
                                output logic err, output logic [31:0] data, output logic [31:0] nw);
    int nb, sh;
    logic [31:0] mask, raw;
    err  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    nb   = 1 << sz;
    sh   = 8 * int'(a[1:0]);
    mask = (nb >= 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    raw  = (old >> sh) & mask;
    data = raw;
    if (!uns && nb < 4 && raw[8 * nb - 1]) data = raw | ~mask;
    nw = (old & ~(mask << sh)) | ((wd & mask) << sh);
    if (err) begin
      data = '0;
      nw   = old;
    end else if (we) data = '0;
    else nw = old;
  endfunction

  task automatic run_op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input int dly,
                        input bit spur, input bit tmo);
    logic        e_err, g_err, g_ready;
    logic [31:0] e_data, e_new, old, g_data, req_addr, req_din;
    int cyc, rd_n, wr_n, req_n, rdy_cyc, rd_rdy_cyc, wr_first, res_cyc, unstable, both, w;
    old = mem[a[7:2]];
    model(we, sz, uns, a, wd, old, e_err, e_data, e_new);
    if (tmo) begin
      e_err  = 1'b1;
      e_data = '0;
      e_new  = old;
    end
    w = 0;
    while (!OP_READY && w < 8) begin
      @(posedge CLK); #1;
      w++;
    end
    check({tag, " op_ready"}, 32'(OP_READY), 32'd1);
    OP_VALID = 1'b1; OP_WE = we; OP_SIZE = sz; OP_UNSIGNED = uns; OP_ADDR = a; OP_WDATA = wd;
    @(posedge CLK); #1;
    OP_VALID = 1'b0; OP_WE = 1'($urandom); OP_SIZE = 2'($urandom); OP_UNSIGNED = 1'($urandom);
    OP_ADDR = $urandom; OP_WDATA = $urandom;
    cyc = 0; rd_n = 0; wr_n = 0; req_n = 0; rdy_cyc = -1; rd_rdy_cyc = -1; wr_first = -1;
    res_cyc = -1; unstable = 0; both = 0;
    req_addr = '0; req_din = '0; g_data = '0; g_err = 1'b0; g_ready = 1'b0;
    while (res_cyc < 0 && cyc < 60) begin
      DOUT = $urandom;
      if (RES_VALID) begin
        res_cyc = cyc; g_data = RES_DATA; g_err = RES_ERR; g_ready = OP_READY;
      end else begin
        if (RREQ && WE) both++;
        if (RREQ || WE) begin
          if (req_n == 0) begin
            req_addr = ADDR; req_din = DIN;
            if (WE) wr_first = cyc;
          end else if (ADDR !== req_addr || DIN !== req_din) unstable++;
          req_n++;
          if (RREQ) rd_n++; else wr_n++;
          if (!tmo && req_n == dly) begin
            RDY = 1'b1; rdy_cyc = cyc;
            if (RREQ) begin
              DOUT = mem[ADDR[7:2]]; rd_rdy_cyc = cyc;
            end else mem[ADDR[7:2]] = DIN;
          end else if (spur && req_n == 1) RDY = 1'b1;
        end else req_n = 0;
        @(posedge CLK); #1;
        RDY = 1'b0;
        cyc++;
      end
    end
    check({tag, " completed"}, 32'(res_cyc >= 0), 32'd1);
    check({tag, " res_data"}, g_data, e_data);
    check({tag, " res_err"}, 32'(g_err), 32'(e_err));
    check({tag, " we_and_rreq"}, 32'(both), 32'd0);
    check({tag, " req_stable"}, 32'(unstable), 32'd0);
    check({tag, " mem"}, mem[a[7:2]], e_new);
    if (tmo) begin
      check({tag, " tmo_req_cycles"}, 32'(rd_n + wr_n), 32'(TMO));
      check({tag, " tmo_latency"}, 32'(res_cyc), 32'(TMO));
    end else if (e_err) begin
      check({tag, " no_access"}, 32'(rd_n + wr_n), 32'd0);
      check({tag, " err_latency"}, 32'(res_cyc), 32'd0);
    end else begin
      check({tag, " addr"}, req_addr, {a[31:2], 2'b00});
      check({tag, " latency"}, 32'(res_cyc), 32'(rdy_cyc + 1));
      check({tag, " rd_cycles"}, 32'(rd_n), (we && sz == 2'd2) ? 32'd0 : 32'(dly));
      check({tag, " wr_cycles"}, 32'(wr_n), we ? 32'(dly) : 32'd0);
      check({tag, " b2b_ready"}, 32'(g_ready), 32'd1);
      if (we && sz != 2'd2) check({tag, " gap"}, 32'(wr_first - rd_rdy_cyc), 32'd2);
    end
  endtask

  initial begin
    logic [1:0] sz;
    int dly;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    repeat (2) @(posedge CLK);
    #1;
    check("rst op_ready", 32'(OP_READY), 32'd1);
    check("rst res_valid", 32'(RES_VALID), 32'd0);
    check("rst res_err", 32'(RES_ERR), 32'd0);
    check("rst we", 32'(WE), 32'd0);
    check("rst rreq", 32'(RREQ), 32'd0);
    check("rst res_data", RES_DATA, 32'd0);
    check("rst addr", ADDR, 32'd0);
    check("rst din", DIN, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    mem[32'h100 >> 2 & 63] = 32'hDEAD_BEEF;
    run_op("word_load", 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 3, 1'b0, 1'b0);
    mem[32'h103 >> 2 & 63] = 32'h8011_2233;
    run_op("byte_load_s", 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 2, 1'b0, 1'b0);
    run_op("byte_load_u", 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 4, 1'b1, 1'b0);
    mem[32'h102 >> 2 & 63] = 32'h1122_3344;
    run_op("half_store", 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h0000_ABCD, 2, 1'b0, 1'b0);
    check("half_store word", mem[32'h102 >> 2 & 63], 32'hABCD_3344);
    run_op("misaligned", 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 2, 1'b0, 1'b0);
    run_op("timeout_ld", 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 0, 1'b0, 1'b1);

    @(posedge CLK); #1;
    RDY = 1'b1; DOUT = $urandom;
    @(posedge CLK); #1;
    RDY = 1'b0;
    check("late_rdy res_valid", 32'(RES_VALID), 32'd0);
    check("late_rdy op_ready", 32'(OP_READY), 32'd1);
    check("late_rdy rreq", 32'(RREQ), 32'd0);
    run_op("timeout_st", 1'b1, 2'd2, 1'b0, 32'h0000_0080, 32'h1234_5678, 0, 1'b0, 1'b1);

    // Abandon a word store mid-handshake.
    @(posedge CLK); #1;
    OP_VALID = 1'b1; OP_WE = 1'b1; OP_SIZE = 2'd2; OP_ADDR = 32'h0000_0010; OP_WDATA = 32'hCAFE_F00D;
    @(posedge CLK); #1;
    OP_VALID = 1'b0;
    check("rst_mid we_before", 32'(WE), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_mid we", 32'(WE), 32'd0);
    check("rst_mid res_valid", 32'(RES_VALID), 32'd0);
    check("rst_mid op_ready", 32'(OP_READY), 32'd1);
    check("rst_mid addr", ADDR, 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    run_op("post_rst_load", 1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 3, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sz  = 2'($urandom_range(3, 0));
      dly = $urandom_range(6, 2);
      run_op("rand", 1'($urandom), sz, 1'($urandom), $urandom, $urandom, dly,
             (dly >= 3) && 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
